// File: rtl/aes_spi_sequencer.sv
// Host-side sequencer for the AES SPI slaves: sends text/key-size/key, waits for the slave, reads one block back.
// Optional feature: define AES_SEQ_MODE_BYTE_EN to prefix each frame with a command byte (0xE0 encrypt, 0xD0 decrypt).
module aes_spi_sequencer #(
  parameter int BLOCK_BYTES    = 16,
  parameter int MAX_KEY_BYTES  = 32,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       mode,
  input  logic [1:0]                 key_size,
  input  logic [BLOCK_BYTES*8-1:0]   text_in,
  input  logic [MAX_KEY_BYTES*8-1:0] key_in,
  output logic                       busy,
  output logic                       result_valid,
  output logic [BLOCK_BYTES*8-1:0]   result,
  output logic                       error,
  output logic                       spi_start,
  output logic [7:0]                 spi_tx,
  input  logic [7:0]                 spi_rx,
  input  logic                       spi_busy,
  input  logic                       spi_done,
  input  logic                       peer_ready
);

`ifdef AES_SEQ_MODE_BYTE_EN
  localparam int CMD_BYTES = 1;
`else
  localparam int CMD_BYTES = 0;
`endif
  localparam int FRAME_W = (CMD_BYTES + BLOCK_BYTES + 1 + MAX_KEY_BYTES) * 8;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(BLOCK_BYTES + MAX_KEY_BYTES + 3);

  typedef enum logic [3:0] {
    IDLE, CHECK, TX_ISSUE, TX_WAIT, TX_GAP, RDY_WAIT, RX_ISSUE, RX_WAIT, RX_GAP, DONE
  } state_t;

  state_t                   state, state_nx;
  logic [FRAME_W-1:0]       frame, frame_load;
  logic [BLOCK_BYTES*8-1:0] shadow;
  logic [1:0]               ks_q;
  logic [BW-1:0]            rem;
  logic [CW-1:0]            cnt;
  logic                     gap_end, tmo, timeout;

  // The key-size byte on the wire doubles as the key length in bytes.
  function automatic logic [7:0] kb_of(input logic [1:0] ks);
    case (ks)
      2'b01:   return 8'h10;
      2'b10:   return 8'h18;
      2'b11:   return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

`ifdef AES_SEQ_MODE_BYTE_EN
  assign frame_load = {(mode ? 8'hD0 : 8'hE0), text_in, kb_of(key_size), key_in};
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign frame_load  = {text_in, kb_of(key_size), key_in};
`endif

  assign busy    = (state != IDLE);
  assign spi_tx  = (state == TX_ISSUE || state == TX_WAIT || state == TX_GAP) ?
                   frame[FRAME_W-1 -: 8] : 8'h00;
  assign gap_end = (cnt == CW'(GAP_CYCLES - 1));
  assign tmo     = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    spi_start = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      IDLE:  if (req) state_nx = CHECK;
      CHECK: state_nx = (ks_q == 2'b00) ? IDLE : TX_ISSUE;
      TX_ISSUE, RX_ISSUE: begin
        if (!spi_busy) begin
          spi_start = 1'b1;
          state_nx  = (state == TX_ISSUE) ? TX_WAIT : RX_WAIT;
        end else if (tmo) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      TX_WAIT, RX_WAIT: begin
        if (spi_done) begin
          state_nx = (state == TX_WAIT) ? TX_GAP : RX_GAP;
        end else if (tmo) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      TX_GAP: if (gap_end) state_nx = (rem == '0) ? RDY_WAIT : TX_ISSUE;
      RX_GAP: if (gap_end) state_nx = (rem == '0) ? DONE : RX_ISSUE;
      RDY_WAIT: begin
        if (peer_ready) begin
          state_nx = RX_ISSUE;
        end else if (tmo) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      frame        <= '0;
      shadow       <= '0;
      ks_q         <= 2'b00;
      rem          <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nx;
      result_valid <= (state == DONE);
      // One counter serves gap timing and timeouts; it restarts on every state change.
      cnt          <= (state_nx != state || state == IDLE) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (req) begin
          frame  <= frame_load;
          ks_q   <= key_size;
          shadow <= '0;
          error  <= 1'b0;
        end
        CHECK: begin
          if (ks_q == 2'b00) error <= 1'b1;
          else rem <= BW'(CMD_BYTES + BLOCK_BYTES + 1) + BW'(kb_of(ks_q));
        end
        TX_WAIT: if (spi_done) begin
          frame <= frame << 8;
          rem   <= rem - BW'(1);
        end
        RDY_WAIT: if (peer_ready) rem <= BW'(BLOCK_BYTES);
        RX_WAIT: if (spi_done) begin
          shadow <= {shadow[BLOCK_BYTES*8-9:0], spi_rx};
          rem    <= rem - BW'(1);
        end
        DONE:    result <= shadow;
        default: ;
      endcase
      if (timeout) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Scoreboard bench for aes_spi_sequencer: SPI master/slave model, expected tx bytes and results queued per request.
// Define AES_SEQ_MODE_BYTE_EN for both files to exercise the command-byte frame.
module tb_aes_spi_sequencer;
  localparam int GAP = 4;
  localparam int TMO = 64;
`ifdef AES_SEQ_MODE_BYTE_EN
  localparam int CMD_BYTES = 1;
`else
  localparam int CMD_BYTES = 0;
`endif

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk, reset, req, mode;
  logic [1:0]   key_size;
  logic [127:0] text_in;
  logic [255:0] key_in;
  logic         busy, result_valid, error, spi_start;
  logic [127:0] result;
  logic [7:0]   spi_tx, spi_rx;
  logic         spi_busy, spi_done, peer_ready;

  int checks = 0;
  int errors = 0;
  int cyc_now = 0;
  int start_cnt = 0;
  int xfer_cnt = 0;
  int slave_n = 0;
  int last_done_cyc = 0;
  bit slave_ready_en = 1'b0;
  logic [127:0] slave_resp = '0;

  logic [7:0]   txq[$];
  logic [127:0] resq[$];

  aes_spi_sequencer #(
    .BLOCK_BYTES(16), .MAX_KEY_BYTES(32), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode), .key_size(key_size),
    .text_in(text_in), .key_in(key_in), .busy(busy), .result_valid(result_valid),
    .result(result), .error(error), .spi_start(spi_start), .spi_tx(spi_tx),
    .spi_rx(spi_rx), .spi_busy(spi_busy), .spi_done(spi_done), .peer_ready(peer_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_now++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected wire order: [cmd], text MSB first, key-size byte, top KB key bytes, then dummy 0x00 for readback.
  task automatic push_frame(input logic [127:0] text, input logic [255:0] key,
                            input logic [1:0] ks, input bit with_rx);
    int kb;
    kb = (ks == 2'b01) ? 16 : (ks == 2'b10) ? 24 : (ks == 2'b11) ? 32 : 0;
`ifdef AES_SEQ_MODE_BYTE_EN
    txq.push_back(mode ? 8'hD0 : 8'hE0);
`endif
    for (int i = 15; i >= 0; i--) txq.push_back(text[i*8 +: 8]);
    txq.push_back(8'(kb));
    for (int i = 0; i < kb; i++) txq.push_back(key[255-8*i -: 8]);
    if (with_rx) for (int i = 0; i < 16; i++) txq.push_back(8'h00);
  endtask

  // Monitor: every spi_start and every result_valid pops the scoreboard.
  initial forever begin
    logic [7:0]   exp_b;
    logic [127:0] exp_r;
    @(negedge clk);
    if (spi_start) begin
      start_cnt++;
      if (txq.size() == 0) begin
        checks++; errors++;
        $display("FAIL spi_start_unexpected: got tx %h expected no transfer", spi_tx);
      end else begin
        exp_b = txq.pop_front();
        check("spi_tx", 128'(spi_tx), 128'(exp_b));
      end
    end
    if (result_valid) begin
      if (resq.size() == 0) begin
        checks++; errors++;
        $display("FAIL result_valid_unexpected: got %h expected no result", result);
      end else begin
        exp_r = resq.pop_front();
        check("result", result, exp_r);
      end
    end
  end

  // SPI master + slave model: 3-cycle transfers; slave raises peer_ready once the whole frame arrived.
  initial begin
    logic [7:0] tx_byte;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rx = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        tx_byte = spi_tx;
        @(posedge clk); #1 spi_busy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (xfer_cnt < slave_n) spi_rx = 8'hA5;
        else spi_rx = slave_resp[127-8*(xfer_cnt-slave_n) -: 8];
        spi_busy = 1'b0;
        spi_done = 1'b1;
        last_done_cyc = cyc_now;
        if (busy) check("spi_tx_hold", 128'(spi_tx), 128'(tx_byte));
        xfer_cnt++;
        if (xfer_cnt == slave_n && slave_ready_en) peer_ready = 1'b1;
        @(posedge clk); #1 spi_done = 1'b0;
      end
    end
  end

  task automatic setup(input logic [127:0] text, input logic [255:0] key, input logic [1:0] ks,
                       input logic md, input logic [127:0] resp, input bit ready_en, input int n);
    text_in = text; key_in = key; key_size = ks; mode = md;
    xfer_cnt = 0; slave_n = n; slave_resp = resp; slave_ready_en = ready_en;
    peer_ready = 1'b0; start_cnt = 0;
  endtask

  task automatic run_txn(input string name, input logic [127:0] text, input logic [255:0] key,
                         input logic [1:0] ks, input logic md, input logic [127:0] resp,
                         input bit ready_en, input bit exp_err, input int exp_frame,
                         input int poke, output int dur, output int end_cyc);
    int exp_starts;
    setup(text, key, ks, md, resp, ready_en, exp_frame);
    if (ks != 2'b00) push_frame(text, key, ks, !exp_err);
    if (!exp_err) resq.push_back(resp);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    dur = 0;
    while (busy && dur < 3000) begin
      @(posedge clk); #1;
      dur++;
      req = (dur == poke);
      if (dur == poke) text_in = ~text;
    end
    req = 1'b0;
    end_cyc = cyc_now;
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s_done: busy still 1 after %0d cycles, expected 0", name, dur);
    end
    check({name, "_error"}, 128'(error), 128'(exp_err));
    exp_starts = (ks == 2'b00) ? 0 : exp_frame + (exp_err ? 0 : 16);
    repeat (3) @(negedge clk);
    check({name, "_starts"}, 128'(start_cnt), 128'(exp_starts));
    check({name, "_txq_left"}, 128'(txq.size()), 128'(0));
    check({name, "_resq_left"}, 128'(resq.size()), 128'(0));
    txq.delete();
    resq.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int dur, end_cyc, wait_cnt;
    reset = 1'b1; req = 1'b0; mode = 1'b0; key_size = 2'b00;
    text_in = '0; key_in = '0; peer_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_result_valid", 128'(result_valid), 128'(0));
    check("rst_result", result, 128'(0));
    check("rst_error", 128'(error), 128'(0));
    check("rst_spi_start", 128'(spi_start), 128'(0));
    check("rst_spi_tx", 128'(spi_tx), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn("t1_k128", PT, K128, 2'b01, 1'b0, C128, 1'b1, 1'b0, 33 + CMD_BYTES, 0, dur, end_cyc);
    run_txn("t2_k192_poke", PT, K192, 2'b10, 1'b0, C192, 1'b1, 1'b0, 41 + CMD_BYTES, 60, dur, end_cyc);
    run_txn("t2_k256", PT, K256, 2'b11, 1'b0, C256, 1'b1, 1'b0, 49 + CMD_BYTES, 0, dur, end_cyc);

    run_txn("t3_illegal", PT, K128, 2'b00, 1'b0, C128, 1'b1, 1'b1, 0, 0, dur, end_cyc);
    check("t3_latency_le2", 128'(dur <= 2), 128'(1));
    check("t3_result_kept", result, C256);

    run_txn("t4_timeout", PT, K128, 2'b01, 1'b0, C128, 1'b0, 1'b1, 33 + CMD_BYTES, 0, dur, end_cyc);
    check("t4_latency", 128'(end_cyc - last_done_cyc), 128'(1 + GAP + TMO));
    check("t4_result_kept", result, C256);

    setup(PT, K128, 2'b01, 1'b0, C128, 1'b1, 33 + CMD_BYTES);
    push_frame(PT, K128, 2'b01, 1'b1);
    resq.push_back(C128);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_cnt = 0;
    while (start_cnt < 10 && wait_cnt < 500) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("t5_reach_byte10", 128'(start_cnt), 128'(10));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_spi_start", 128'(spi_start), 128'(0));
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_error", 128'(error), 128'(0));
    check("t5_result", result, 128'(0));
    txq.delete();
    resq.delete();
    repeat (8) @(posedge clk);
    #1;
    check("t5_no_restart", 128'(start_cnt), 128'(10));
    run_txn("t5_clean", PT, K128, 2'b01, 1'b0, C128, 1'b1, 1'b0, 33 + CMD_BYTES, 0, dur, end_cyc);

    run_txn("t6_decrypt", C128, K128, 2'b01, 1'b1, PT, 1'b1, 1'b0, 33 + CMD_BYTES, 0, dur, end_cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_spi_sequencer.md
Name: aes_spi_sequencer

Overview:
Synthesizable host-side sequencer that replaces the hand-written bench stimulus for the AES SPI slaves.
- Latches one plaintext/ciphertext block, a key and a key size.
- Streams the frame byte-by-byte through the existing SPI master's byte interface.
- Waits for the slave's result-ready flag, clocks back one result block and presents it with a valid pulse.
- Generalised over block width, key width, inter-byte gap and timeout; supports 128/192/256-bit keys and encrypt/decrypt.

Parameters:
BLOCK_BYTES, 16, bytes per data block (text and result)
MAX_KEY_BYTES, 32, width of key_in in bytes; key is left-justified (MSB-aligned)
GAP_CYCLES, 4, idle cycles between consecutive byte transfers (min 1)
TIMEOUT_CYCLES, 1024, max cycles spent in any single wait state before error

Ports:
clk  in  1  system clock; everything on rising edge
reset  in  1  synchronous, active-high reset
req  in  1  start request; sampled only in IDLE
mode  in  1  0 = encrypt, 1 = decrypt (used only with the optional feature)
key_size  in  2  01 = 128, 10 = 192, 11 = 256, 00 = illegal
text_in  in  BLOCK_BYTES*8  block to process; MSB byte sent first
key_in  in  MAX_KEY_BYTES*8  key, MSB-aligned
busy  out  1  high from the cycle after req is accepted until return to IDLE
result_valid  out  1  one-cycle pulse; result is valid on this cycle and held until the next accepted req
result  out  BLOCK_BYTES*8  received block; first received byte lands in the MSB
error  out  1  sticky; set on illegal key_size or timeout, cleared on next accepted req
spi_start  out  1  one-cycle pulse to master start
spi_tx  out  8  byte to master data_in; held stable from spi_start until spi_done
spi_rx  in  8  master data_out; valid on spi_done
spi_busy  in  1  master busy
spi_done  in  1  master byte-complete pulse
peer_ready  in  1  slave has result available (enc_sending equivalent)

Behaviour:
Reset values: busy = 0, result_valid = 0, result = 0, error = 0, spi_start = 0, spi_tx = 0x00. State returns to IDLE.

Reset mid-operation:
- spi_start is 0 on the following cycle.
- No partial result is exposed.

States and transitions:
- IDLE: on req = 1, latch text_in, key_in, key_size and mode, clear error, go to CHECK.
- CHECK (1 cycle):
  - key_size = 00: set error, go to IDLE; result_valid stays 0.
  - Otherwise: compute KB = 16/24/32, frame length N = BLOCK_BYTES + 1 + KB (+1 with the optional feature), go to TX_ISSUE.
- Frame order:
  - [cmd byte] (optional feature only)
  - text bytes, MSB first
  - key-size byte = KB (0x10 / 0x18 / 0x20)
  - top KB bytes of key_in, MSB first
- TX_ISSUE:
  - Wait while spi_busy = 1.
  - Then drive spi_tx and pulse spi_start for exactly 1 cycle, go to TX_WAIT.
- TX_WAIT: on spi_done, go to TX_GAP.
- TX_GAP: count GAP_CYCLES cycles, then go to TX_ISSUE for the next byte, or to RDY_WAIT after byte N.
- RDY_WAIT: on peer_ready = 1, go to RX_ISSUE.
- RX_ISSUE / RX_WAIT / RX_GAP: same handshake as TX, with these differences:
  - spi_tx = 0x00.
  - On spi_done, shift spi_rx into a shadow register.
  - After BLOCK_BYTES bytes, go to DONE.
- DONE (1 cycle): copy shadow to result, pulse result_valid, go to IDLE. busy falls on the cycle after DONE.

Timeout:
- A single counter reloads on entry to TX_ISSUE, TX_WAIT, RDY_WAIT, RX_ISSUE and RX_WAIT.
- If it reaches TIMEOUT_CYCLES: set error, go to IDLE, discard partial data; result is unchanged.

Other boundary rules:
- req while busy: ignored.
- req in the same cycle as DONE: ignored.
- spi_done while in any *_ISSUE or *_GAP state: ignored.
- peer_ready that is already high on entry to RDY_WAIT: accepted the next cycle.
- Byte counter width: clog2(BLOCK_BYTES + MAX_KEY_BYTES + 3). No wrap is possible within a frame.

Optional Feature:
Macro AES_SEQ_MODE_BYTE_EN.
- Defined: a command byte is sent first, 0xE0 for mode = 0 and 0xD0 for mode = 1, and N increases by 1. One sequencer drives either the encrypt or the decrypt slave.
- Undefined: no command byte, mode is ignored, and the frame starts with text.

Test Plan:
1. 128-bit encrypt:
   - Stimulus: text 00112233445566778899aabbccddeeff, key 000102…0f followed by zeros, key_size = 01, slave model in the loop.
   - Response: 33 spi_start pulses, tx bytes in the documented order; result = 69c4e0d86a7b0430d8cdb78070b4c55a with one result_valid pulse; error = 0.
2. 192-bit and 256-bit keys:
   - Stimulus: the same text with key_size = 10 and key_size = 11.
   - Response: 41 and 49 frame bytes; key-size byte 0x18 and 0x20; results dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089.
3. Illegal key and ignored req:
   - Stimulus: key_size = 00; separately, req pulsed mid-frame.
   - Response: for key_size = 00, error = 1 within 2 cycles, no spi_start, no result_valid. The mid-frame req is ignored and the byte count is unchanged.
4. Timeout:
   - Stimulus: peer_ready held low with TIMEOUT_CYCLES = 64.
   - Response: error rises 64 cycles after RDY_WAIT entry; busy falls; result retains its previous value.
5. Reset mid-operation:
   - Stimulus: reset asserted during the 10th TX byte.
   - Response: the next cycle shows spi_start = 0, busy = 0, error = 0; a following req runs a clean full frame.
6. AES_SEQ_MODE_BYTE_EN defined:
   - Stimulus: decrypt, mode = 1, key_size = 01, with the decrypt slave.
   - Response: first byte 0xD0, 34 bytes total; result = 00112233445566778899aabbccddeeff.
